// File: rtl/sap_defs_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-states and control-word bit indices.
package sap_defs;

  // Opcode nibbles (IR upper nibble)
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // One-hot T-states, bit0 = T1
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Control-word bit indices
  localparam int unsigned CW_W        = 12;
  localparam int unsigned CW_PC_INC   = 0;
  localparam int unsigned CW_PC_OUT   = 1;
  localparam int unsigned CW_MAR_LOAD = 2;
  localparam int unsigned CW_RAM_OUT  = 3;
  localparam int unsigned CW_IR_LOAD  = 4;
  localparam int unsigned CW_IR_OUT   = 5;
  localparam int unsigned CW_A_LOAD   = 6;
  localparam int unsigned CW_A_OUT    = 7;
  localparam int unsigned CW_ALU_SUB  = 8;
  localparam int unsigned CW_ALU_OUT  = 9;
  localparam int unsigned CW_B_LOAD   = 10;
  localparam int unsigned CW_OUT_LOAD = 11;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/t_state_ring_counter.sv
// Six-bit one-hot T-state ring. clear and restart both return to T1; hold freezes the ring.
module t_state_ring_counter
  import sap_defs::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       hold,
  input  logic       restart,
  output logic [5:0] t
);

  logic [5:0] t_q;

  // Ring advance with synchronous clear; clear beats hold, hold beats restart
  always_ff @(posedge clk) begin
    if (clear) begin
      t_q <= T1;
    end else if (hold) begin
      t_q <= t_q;
    end else if (restart) begin
      t_q <= T1;
    end else begin
      t_q <= {t_q[4:0], t_q[5]};
    end
  end

  assign t = t_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: one-hot T-state ring plus opcode decode into the control word.
// Optional build macro SEQ_VAR_CYCLE_EN shortens LDA/OUT/NOP machine cycles by restarting
// the ring at T1 after the last active T-state; without it every instruction takes 6 states.
module control_sequencer
  import sap_defs::*;
#(
  parameter int unsigned OP_W          = 4,
  parameter bit          HALT_ON_UNDEF = 1'b0
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [OP_W-1:0] opcode,
  input  logic            prog_mode,
  output logic [5:0]      t_state,
  output logic            pc_inc,
  output logic            pc_out,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            alu_sub,
  output logic            alu_out,
  output logic            b_load,
  output logic            out_load,
  output logic            halt
);

  logic [5:0] ring_t;
  logic       halt_q;
  logic       restart;
  logic       is_lda, is_add, is_sub, is_out, is_hlt, is_undef, halt_op;
  ctrl_word_t cw;

  // Opcode class decode
  always_comb begin
    is_lda   = (opcode == OP_W'(OP_LDA));
    is_add   = (opcode == OP_W'(OP_ADD));
    is_sub   = (opcode == OP_W'(OP_SUB));
    is_out   = (opcode == OP_W'(OP_OUT));
    is_hlt   = (opcode == OP_W'(OP_HLT));
    is_undef = !(is_lda || is_add || is_sub || is_out || is_hlt);
    halt_op  = is_hlt || (HALT_ON_UNDEF && is_undef);
  end

  // Early return to T1 once the instruction has no more work to do
  always_comb begin
    restart = 1'b0;
`ifdef SEQ_VAR_CYCLE_EN
    if (ring_t == T5 && is_lda) restart = 1'b1;
    if (ring_t == T4 && (is_out || (is_undef && !halt_op))) restart = 1'b1;
`endif
  end

  t_state_ring_counter u_ring (
    .clk     (clk),
    .clear   (clear),
    .hold    (prog_mode | halt_q),
    .restart (restart),
    .t       (ring_t)
  );

  // HALT is entered from T4 of a halting opcode and left only through clear
  always_ff @(posedge clk) begin
    if (clear) begin
      halt_q <= 1'b0;
    end else if (!prog_mode && ring_t == T4 && halt_op) begin
      halt_q <= 1'b1;
    end
  end

  // Control word decode from the registered T-state and the current opcode
  always_comb begin
    cw = '0;
    if (!clear && !prog_mode && !halt_q) begin
      unique case (ring_t)
        T1: begin
          cw[CW_PC_OUT]   = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_IR_LOAD] = 1'b1;
        end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            cw[CW_IR_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end else if (is_out) begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
          end else if (is_add || is_sub) begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = is_sub;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            cw[CW_ALU_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = is_sub;
          end
        end
        default: cw = '0;
      endcase
    end
  end

  // halt is visible combinationally in T4 of HLT so it covers the whole T4 state
  assign halt    = !clear && (halt_q || (ring_t == T4 && halt_op));
  assign t_state = halt_q ? 6'b000000 : ring_t;

  assign pc_inc   = cw[CW_PC_INC];
  assign pc_out   = cw[CW_PC_OUT];
  assign mar_load = cw[CW_MAR_LOAD];
  assign ram_out  = cw[CW_RAM_OUT];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_out   = cw[CW_IR_OUT];
  assign a_load   = cw[CW_A_LOAD];
  assign a_out    = cw[CW_A_OUT];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign alu_out  = cw[CW_ALU_OUT];
  assign b_load   = cw[CW_B_LOAD];
  assign out_load = cw[CW_OUT_LOAD];

endmodule
